// File: rtl/shared_adder_arbiter.sv
// Round-robin arbiter sharing one registered adder among NUM_REQ requesters.
// Define SHARED_ADDER_SAT_EN for signed saturating adds (res_carry = overflow).
`timescale 1ns/1ps
module shared_adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_sum,
  output logic                     res_carry,
  output logic [IDW-1:0]           res_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [IDW:0]   NUM_REQ_EXT = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID     = IDW'(NUM_REQ-1);

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   grant_idx;
  logic             grant_found;
  logic [IDW:0]     cand;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_val;
  logic             carry_val;

  // Circular search starting at ptr; cand is one bit wider so the wrap never overflows.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= NUM_REQ_EXT)
        cand = cand - NUM_REQ_EXT;
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  assign can_accept = (state == EMPTY) || res_ready;
  assign accept     = can_accept && grant_found && !rst;

  always_comb begin
    op_a = req_a[grant_idx*WIDTH +: WIDTH];
    op_b = req_b[grant_idx*WIDTH +: WIDTH];
  end

`ifdef SHARED_ADDER_SAT_EN
  logic [WIDTH-1:0] raw_sum;
  logic             overflow;

  // Signed overflow: operands agree in sign but the raw sum does not.
  always_comb begin
    raw_sum  = op_a + op_b;
    overflow = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (raw_sum[WIDTH-1] != op_a[WIDTH-1]);
    if (overflow)
      sum_val = op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      sum_val = raw_sum;
    carry_val = overflow;
  end
`else
  logic [WIDTH:0] sum_ext;

  always_comb begin
    sum_ext   = {1'b0, op_a} + {1'b0, op_b};
    sum_val   = sum_ext[WIDTH-1:0];
    carry_val = sum_ext[WIDTH];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= EMPTY;
    else
      state <= state_nxt;
  end

  // An accept while FULL overwrites the register, so FULL persists at full throughput.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept) state_nxt = FULL;
      FULL: begin
        if (accept)
          state_nxt = FULL;
        else if (res_ready)
          state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept)
      req_ready[grant_idx] = 1'b1;
    res_valid = (state == FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      res_sum   <= '0;
      res_carry <= 1'b0;
      res_id    <= '0;
    end else if (accept) begin
      res_sum   <= sum_val;
      res_carry <= carry_val;
      res_id    <= grant_idx;
      ptr       <= (grant_idx == LAST_ID) ? '0 : grant_idx + IDW'(1);
    end
  end

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Directed self-checking bench for shared_adder_arbiter (4 requesters, 32-bit).
// Expectations follow SHARED_ADDER_SAT_EN when it is defined.
`timescale 1ns/1ps
module tb_shared_adder_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int IDW     = 2;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     res_valid;
  logic                     res_ready;
  logic [WIDTH-1:0]         res_sum;
  logic                     res_carry;
  logic [IDW-1:0]           res_id;

  int n_checks;
  int n_fails;

  shared_adder_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_carry(res_carry), .res_id(res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    res_ready = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      n_checks++;
      if (req_ready !== 4'b0000) begin n_fails++; $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready); end
      n_checks++;
      if (res_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_valid: got %b expected 0", res_valid); end
    end
    n_checks++;
    if (res_sum !== 32'h0 || res_carry !== 1'b0 || res_id !== 2'd0) begin
      n_fails++; $display("[TB] FAIL reset_regs: got sum %h carry %b id %0d expected 0/0/0", res_sum, res_carry, res_id);
    end
    rst = 1'b0; #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fails++; $display("[TB] FAIL reset_first_grant: got %b expected 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_op(2, 32'd1, 32'd2);
    req_valid = 4'b0100;
    res_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin n_fails++; $display("[TB] FAIL single_ready: got %b expected 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    n_checks++;
    if (res_valid !== 1'b1 || res_sum !== 32'd3 || res_carry !== 1'b0 || res_id !== 2'd2) begin
      n_fails++; $display("[TB] FAIL single_result: got v%b sum %h c%b id %0d expected v1 sum 3 c0 id 2", res_valid, res_sum, res_carry, res_id);
    end
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL single_drain: got %b expected 0", res_valid); end
  endtask

  task automatic test_round_robin();
    int          rr_ids[5]   = '{0, 1, 2, 3, 0};
    logic [31:0] rr_sums[5]  = '{32'd100, 32'd201, 32'd302, 32'd403, 32'd100};
    logic [3:0]  rr_ready[5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_op(0, 32'd100, 32'd0);
    set_op(1, 32'd200, 32'd1);
    set_op(2, 32'd300, 32'd2);
    set_op(3, 32'd400, 32'd3);
    req_valid = 4'b1111;
    res_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fails++; $display("[TB] FAIL rr_first_grant: got %b expected 0001", req_ready); end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || res_id !== 2'(rr_ids[j]) || res_sum !== rr_sums[j]) begin
        n_fails++; $display("[TB] FAIL rr_result%0d: got v%b id %0d sum %0d expected v1 id %0d sum %0d", j, res_valid, res_id, res_sum, rr_ids[j], rr_sums[j]);
      end
      n_checks++;
      if (req_ready !== rr_ready[j]) begin n_fails++; $display("[TB] FAIL rr_ready%0d: got %b expected %b", j, req_ready, rr_ready[j]); end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    set_op(1, 32'd10, 32'd20);
    req_valid = 4'b0010;
    res_ready = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fails++; $display("[TB] FAIL bp_first_ready: got %b expected 0010", req_ready); end
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || res_sum !== 32'd30 || res_id !== 2'd1) begin
      n_fails++; $display("[TB] FAIL bp_first_result: got v%b sum %0d id %0d expected v1 sum 30 id 1", res_valid, res_sum, res_id);
    end
    set_op(1, 32'd5, 32'd6);
    set_op(3, 32'd7, 32'd8);
    req_valid = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (req_ready !== 4'b0000) begin n_fails++; $display("[TB] FAIL bp_stall_ready%0d: got %b expected 0000", c, req_ready); end
      n_checks++;
      if (res_valid !== 1'b1 || res_sum !== 32'd30 || res_carry !== 1'b0 || res_id !== 2'd1) begin
        n_fails++; $display("[TB] FAIL bp_stall_hold%0d: got v%b sum %0d c%b id %0d expected v1 sum 30 c0 id 1", c, res_valid, res_sum, res_carry, res_id);
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) begin n_fails++; $display("[TB] FAIL bp_release_ready: got %b expected 1000", req_ready); end
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || res_sum !== 32'd15 || res_id !== 2'd3) begin
      n_fails++; $display("[TB] FAIL bp_release_result: got v%b sum %0d id %0d expected v1 sum 15 id 3", res_valid, res_sum, res_id);
    end
    req_valid = '0;
  endtask

  task automatic test_carry();
    logic [31:0] exp_sum1;
    logic [31:0] exp_sum2;
`ifdef SHARED_ADDER_SAT_EN
    logic [31:0] a1 = 32'h7FFF_FFFF;
    exp_sum1 = 32'h7FFF_FFFF;
    exp_sum2 = 32'h8000_0000;
`else
    logic [31:0] a1 = 32'hFFFF_FFFF;
    exp_sum1 = 32'h0000_0000;
    exp_sum2 = 32'h7FFF_FFFF;
`endif
    @(negedge clk);
    set_op(0, a1, 32'd1);
    req_valid = 4'b0001;
    res_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fails++; $display("[TB] FAIL carry_ready0: got %b expected 0001", req_ready); end
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || res_sum !== exp_sum1 || res_carry !== 1'b1 || res_id !== 2'd0) begin
      n_fails++; $display("[TB] FAIL carry_pos: got v%b sum %h c%b id %0d expected v1 sum %h c1 id 0", res_valid, res_sum, res_carry, res_id, exp_sum1);
    end
    set_op(1, 32'h8000_0000, 32'hFFFF_FFFF);
    req_valid = 4'b0010;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fails++; $display("[TB] FAIL carry_ready1: got %b expected 0010", req_ready); end
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || res_sum !== exp_sum2 || res_carry !== 1'b1 || res_id !== 2'd1) begin
      n_fails++; $display("[TB] FAIL carry_neg: got v%b sum %h c%b id %0d expected v1 sum %h c1 id 1", res_valid, res_sum, res_carry, res_id, exp_sum2);
    end
    req_valid = '0;
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    set_op(2, 32'd3, 32'd4);
    req_valid = 4'b0100;
    res_ready = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin n_fails++; $display("[TB] FAIL midrst_ready: got %b expected 0100", req_ready); end
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || res_sum !== 32'd7 || res_id !== 2'd2) begin
      n_fails++; $display("[TB] FAIL midrst_full: got v%b sum %0d id %0d expected v1 sum 7 id 2", res_valid, res_sum, res_id);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fails++; $display("[TB] FAIL midrst_ready_in_reset: got %b expected 0000", req_ready); end
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || res_sum !== 32'd0 || res_carry !== 1'b0 || res_id !== 2'd0) begin
      n_fails++; $display("[TB] FAIL midrst_cleared: got v%b sum %0d c%b id %0d expected all 0", res_valid, res_sum, res_carry, res_id);
    end
    req_valid = 4'b1111;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fails++; $display("[TB] FAIL midrst_ptr: got %b expected 0001", req_ready); end
    req_valid = '0;
    res_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL midrst_no_result%0d: got %b expected 0", c, res_valid); end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst       = 1'b1;
    req_valid = '0;
    res_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_carry();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
